// File: rtl/spi_slave.sv
// SPI slave front end for a small RAM.
// Receives a command/address/data frame on MOSI (MSB first) and presents it to
// the RAM as rx_data with a one-cycle rx_valid strobe. For read-data frames it
// waits for tx_valid, then shifts tx_data out on MISO (MSB first).
//
// Ports:
//   clk       system clock, everything on the rising edge
//   rst_n     synchronous active-low reset
//   SS_n      active-low slave select from the SPI master
//   MOSI      serial data in
//   MISO      serial data out (registered, 0 when not shifting)
//   rx_data   received frame: [ADDR_SIZE+1:ADDR_SIZE] command, rest payload
//   rx_valid  one-cycle strobe qualifying rx_data
//   tx_data   read data from the RAM
//   tx_valid  RAM read data valid level
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | slave not selected, waiting for SS_n low
// CHK_CMD   | first frame bit sampled, picks the transaction path
// WRITE     | collecting a write frame, then parked until SS_n high
// READ_ADD  | collecting a read-address frame, sets rd_addr_done at the end
// READ_DATA | collecting a read-data frame, then waiting/shifting tx_data
module spi_slave #(
  parameter int MEM_DEPTH = 256,
  localparam int ADDR_SIZE = $clog2(MEM_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 SS_n,
  input  logic                 MOSI,
  output logic                 MISO,
  output logic [ADDR_SIZE+1:0] rx_data,
  output logic                 rx_valid,
  input  logic [ADDR_SIZE-1:0] tx_data,
  input  logic                 tx_valid
);

  localparam int FW  = ADDR_SIZE + 2;
  localparam int CW  = $clog2(ADDR_SIZE + 2);
  localparam int TCW = (ADDR_SIZE > 1) ? $clog2(ADDR_SIZE) : 1;

  typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [FW-1:0]        frame_q, frame_d;
  logic                 done_q, done_d;
  logic [FW-1:0]        rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 miso_q, miso_d;
  logic                 rd_addr_done_q, rd_addr_done_d;
  logic [ADDR_SIZE-1:0] tx_shift_q, tx_shift_d;
  logic [TCW-1:0]       tx_cnt_q, tx_cnt_d;
  logic                 busy_q, busy_d;
  logic                 loaded_q, loaded_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      frame_q        <= '0;
      done_q         <= 1'b0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      miso_q         <= 1'b0;
      rd_addr_done_q <= 1'b0;
      tx_shift_q     <= '0;
      tx_cnt_q       <= '0;
      busy_q         <= 1'b0;
      loaded_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      frame_q        <= frame_d;
      done_q         <= done_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      miso_q         <= miso_d;
      rd_addr_done_q <= rd_addr_done_d;
      tx_shift_q     <= tx_shift_d;
      tx_cnt_q       <= tx_cnt_d;
      busy_q         <= busy_d;
      loaded_q       <= loaded_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    frame_d        = frame_q;
    done_d         = done_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    miso_d         = 1'b0;
    rd_addr_done_d = rd_addr_done_q;
    tx_shift_d     = tx_shift_q;
    tx_cnt_d       = tx_cnt_q;
    busy_d         = busy_q;
    loaded_d       = loaded_q;

    if (SS_n) begin
      // Deselect aborts whatever is in flight; rd_addr_done survives.
      state_d  = IDLE;
      cnt_d    = '0;
      done_d   = 1'b0;
      busy_d   = 1'b0;
      loaded_d = 1'b0;
      tx_cnt_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d  = CHK_CMD;
          cnt_d    = '0;
          done_d   = 1'b0;
          loaded_d = 1'b0;
        end
        CHK_CMD: begin
          frame_d = {{(FW-1){1'b0}}, MOSI};
          // Down-counter over the remaining ADDR_SIZE+1 bits; bit 0 at zero.
          cnt_d   = CW'(ADDR_SIZE);
          if (!MOSI)               state_d = WRITE;
          else if (rd_addr_done_q) state_d = READ_DATA;
          else                     state_d = READ_ADD;
        end
        WRITE, READ_ADD, READ_DATA: begin
          if (!done_q) begin
            frame_d = {frame_q[FW-2:0], MOSI};
            if (cnt_q == '0) begin
              done_d     = 1'b1;
              rx_data_d  = frame_d;
              rx_valid_d = 1'b1;
              if (state_q == READ_ADD) rd_addr_done_d = 1'b1;
            end else begin
              cnt_d = cnt_q - CW'(1);
            end
          end else if (state_q == READ_DATA) begin
            if (busy_q) begin
              if (tx_cnt_q != '0) begin
                miso_d     = tx_shift_q[ADDR_SIZE-1];
                tx_shift_d = tx_shift_q << 1;
                tx_cnt_d   = tx_cnt_q - TCW'(1);
              end else begin
                busy_d = 1'b0;
              end
            end else if (!loaded_q && tx_valid) begin
              // MSB goes out now; the shifter keeps the remaining bits.
              miso_d         = tx_data[ADDR_SIZE-1];
              tx_shift_d     = tx_data << 1;
              tx_cnt_d       = TCW'(ADDR_SIZE - 1);
              busy_d         = 1'b1;
              loaded_d       = 1'b1;
              rd_addr_done_d = 1'b0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign MISO     = miso_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave.sv
module tb_spi_slave;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: last delivered frame and the read-address-seen flag.
  logic [9:0] last_rx = '0;
  logic       rd_done_m = 1'b0;

  always #5 clk = ~clk;

  spi_slave #(.MEM_DEPTH(256)) dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // One SS_n-low window of n_low edges followed by one SS_n-high edge.
  // Expected behaviour is derived from edge indices: edge 1 selects, edges
  // 2..11 carry frame bits 9..0, the strobe lands on edge 11, and read data
  // appears on 8 edges starting at the first edge >= 12 with tx_valid high.
  task automatic run_frame(input logic [9:0] frame, input int n_low, input int d,
                           input int rst_at, input int txval);
    logic       rd_path, ra_path, found, tv, exp_miso, did_rst;
    logic [7:0] txd, tdrv;
    int         L;
    rd_path = frame[9] && rd_done_m;
    ra_path = frame[9] && !rd_done_m;
    found   = 1'b0;
    did_rst = 1'b0;
    L       = 0;
    txd     = '0;
    for (int e = 1; e <= n_low; e++) begin
      SS_n  = 1'b0;
      rst_n = (e == rst_at) ? 1'b0 : 1'b1;
      MOSI  = (e >= 2 && e <= 11) ? frame[11-e] : 1'($urandom);
      tdrv  = (txval < 0) ? 8'($urandom) : txval[7:0];
      tx_data = tdrv;
      if (rd_path && e >= 12) tv = (e >= 12 + d);
      else                    tv = 1'($urandom);
      tx_valid = tv;
      @(posedge clk);
      @(negedge clk);
      if (e == rst_at) begin
        last_rx   = '0;
        rd_done_m = 1'b0;
        chk("rst_miso", MISO, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_rd_done", dut.rd_addr_done_q, 0);
        rst_n   = 1'b1;
        did_rst = 1'b1;
        break;
      end
      if (e == 11) begin
        last_rx = frame;
        if (ra_path) rd_done_m = 1'b1;
      end
      if (rd_path && e >= 12 && !found && tv) begin
        found     = 1'b1;
        L         = e;
        txd       = tdrv;
        rd_done_m = 1'b0;
      end
      exp_miso = (found && (e - L) < 8) ? txd[7-(e-L)] : 1'b0;
      chk("rx_valid", rx_valid, (e == 11));
      chk("rx_data", rx_data, last_rx);
      chk("miso", MISO, exp_miso);
      chk("rd_done", dut.rd_addr_done_q, rd_done_m);
    end
    SS_n     = 1'b1;
    rst_n    = 1'b1;
    MOSI     = 1'($urandom);
    tx_valid = 1'($urandom);
    tx_data  = 8'($urandom);
    @(posedge clk);
    @(negedge clk);
    chk("idle_rx_valid", rx_valid, 0);
    chk("idle_miso", MISO, 0);
    chk("idle_rx_data", rx_data, last_rx);
    chk("idle_rd_done", dut.rd_addr_done_q, rd_done_m);
    if (!did_rst) chk("idle_state", 32'(dut.state_q), 0);
  endtask

  typedef struct {
    logic [9:0] frame;
    int         n_low;
    int         d;
    int         rst_at;
    int         txval;
    logic [9:0] exp_rx;
    logic       exp_rd;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{10'h0A5, 13, 0,  0, -1,    10'h0A5, 1'b0}; // write address
    vecs[1] = '{10'h23C, 12, 0,  0, -1,    10'h23C, 1'b1}; // read address
    vecs[2] = '{10'h300, 24, 2,  0, 8'hC3, 10'h300, 1'b0}; // read data C3
    vecs[3] = '{10'h0A5,  6, 0,  0, -1,    10'h300, 1'b0}; // abort after 5 bits
    vecs[4] = '{10'h05A, 11, 0,  0, -1,    10'h05A, 1'b0}; // full frame after abort
    vecs[5] = '{10'h311, 11, 0,  0, -1,    10'h311, 1'b1}; // 1,1 without address
    vecs[6] = '{10'h200, 30, 0, 15, -1,    10'h000, 1'b0}; // reset at MISO bit 3

    rst_n = 1'b0; SS_n = 1'b0; MOSI = 1'b1; tx_valid = 1'b0; tx_data = '0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("reset_rx_valid", rx_valid, 0);
      chk("reset_rx_data", rx_data, 0);
      chk("reset_miso", MISO, 0);
      chk("reset_rd_done", dut.rd_addr_done_q, 0);
    end
    rst_n = 1'b1; SS_n = 1'b1;
    @(posedge clk);
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_frame(vecs[i].frame, vecs[i].n_low, vecs[i].d, vecs[i].rst_at, vecs[i].txval);
      chk("table_rx_data", rx_data, vecs[i].exp_rx);
      chk("table_rd_done", dut.rd_addr_done_q, vecs[i].exp_rd);
    end

    for (int i = 0; i < 60; i++) begin
      logic [9:0] fr;
      int nl, dd, ra;
      fr = 10'($urandom);
      nl = int'($urandom_range(3, 26));
      dd = int'($urandom_range(0, 4));
      ra = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, nl)) : 0;
      run_frame(fr, nl, dd, ra, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter MEM_DEPTH, default 256, depth of downstream RAM; ADDR_SIZE = $clog2(MEM_DEPTH), 8 at default.
REQ-002 clk  input  1  single system clock; all logic on rising edge.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004 SS_n  input  1  active-low slave select from SPI master.
REQ-005 MOSI  input  1  serial data in, MSB first, sampled on rising clk.
REQ-006 MISO  output  1  serial data out, MSB first, registered.
REQ-007 rx_data  output  ADDR_SIZE+2  received frame to RAM; bits [ADDR_SIZE+1:ADDR_SIZE] are the RAM command, [ADDR_SIZE-1:0] payload.
REQ-008 rx_valid  output  1  one-cycle strobe qualifying rx_data.
REQ-009 tx_data  input  ADDR_SIZE  read data from RAM.
REQ-010 tx_valid  input  1  level from RAM; high means tx_data holds read result.

Function
REQ-011 FSM states SHALL be IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA; rd_addr_done SHALL be an internal flag.
REQ-012 IDLE: SS_n=0 -> CHK_CMD; no MOSI sample taken.
REQ-013 CHK_CMD: MOSI sampled as frame bit ADDR_SIZE+1; MOSI=0 -> WRITE; MOSI=1 and rd_addr_done=0 -> READ_ADD; MOSI=1 and rd_addr_done=1 -> READ_DATA.
REQ-014 WRITE/READ_ADD/READ_DATA SHALL sample ADDR_SIZE+1 further MOSI bits (bits ADDR_SIZE..0) on consecutive edges via a bit counter.
REQ-015 Edge sampling bit 0: rx_data <= full frame, rx_valid <= 1; rx_valid SHALL be 0 on every other cycle.
REQ-016 rx_valid SHALL rise after the (ADDR_SIZE+3)th rising edge with SS_n low, counted from the IDLE->CHK_CMD edge (11th at default).
REQ-017 rx_data SHALL hold its value between frames; SHALL not change except on a rx_valid edge.
REQ-018 WRITE: after frame, state remains WRITE, no further sampling, until SS_n=1.
REQ-019 READ_ADD: on frame completion rd_addr_done <= 1; then holds until SS_n=1.
REQ-020 READ_DATA: after frame, wait for tx_valid=1; at first edge with tx_valid=1, load tx_data to shift register, MISO <= tx_data[ADDR_SIZE-1], rd_addr_done <= 0.
REQ-021 Following ADDR_SIZE-1 edges SHALL drive remaining bits MSB->LSB on MISO; afterwards MISO <= 0 and no reload until next frame.
REQ-022 MISO SHALL be 0 whenever not shifting read data.
REQ-023 SS_n=1 in any state SHALL force IDLE on next edge, clear bit counter, abort frame without rx_valid, stop MISO shifting (MISO <= 0); rd_addr_done unchanged.
REQ-024 tx_valid SHALL be ignored outside the READ_DATA wait phase.
REQ-025 Back-to-back frames: SS_n high for at least one cycle between frames; SS_n low on the edge after returning to IDLE starts a new frame.
REQ-026 Bit counter width SHALL be $clog2(ADDR_SIZE+2); no wrap beyond frame length.

Reset
REQ-027 rst_n=0 at rising edge SHALL set state IDLE, rx_data=0, rx_valid=0, MISO=0, rd_addr_done=0, counters=0; reset overrides all other inputs.
REQ-028 Reset mid-frame or mid-shift SHALL discard progress; no rx_valid emitted.

Verification
REQ-029 Reset: rst_n=0 two cycles with SS_n=0, MOSI=1 -> all outputs 0, no rx_valid.
REQ-030 Write address: SS_n low, MOSI 0,0,1010_0101 -> rx_valid one cycle after 11th edge, rx_data=10'h0A5; raise SS_n -> IDLE.
REQ-031 Read address then read data: frame 1,0,0011_1100 -> rx_data=10'h23C; next frame 1,1,dummy 0x00 -> rx_data=10'h300; tx_valid=1 with tx_data=8'hC3 -> MISO 1,1,0,0,0,0,1,1 on 8 consecutive cycles, then 0; rd_addr_done cleared.
REQ-032 Abort: SS_n raised after 5 bits of write frame -> no rx_valid, IDLE next edge; subsequent full frame received correctly.
REQ-033 Read without prior address: rd_addr_done=0, first bit 1 -> READ_ADD path taken, rd_addr_done set at frame end.
REQ-034 Mid-shift reset: rst_n=0 during MISO bit 3 -> MISO=0, state IDLE, rd_addr_done=0 next edge.
